// File: rtl/alu_exec.sv
// rtl/alu_exec.sv - multi-cycle ALU with valid/ready handshakes and a bit-serial shifter
//
// Ports:
//   clk, rstn            clock, asynchronous active-low reset
//   flush                synchronous abort of the operation in progress
//   in_valid / in_ready  operation handshake (accepted only in IDLE)
//   funct, op_a, op_b    function code and operands, captured at acceptance
//   out_valid / out_ready result handshake (result held until consumed)
//   result, zero, br_taken  registered result, result==0 flag, branch decision
module alu_exec #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rstn,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [3:0]      funct,
    input  logic [XLEN-1:0] op_a,
    input  logic [XLEN-1:0] op_b,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic            zero,
    output logic            br_taken
);

    localparam logic [3:0] F_AND = 4'b0000;
    localparam logic [3:0] F_OR  = 4'b0001;
    localparam logic [3:0] F_SLL = 4'b0011;
    localparam logic [3:0] F_BEQ = 4'b0100;
    localparam logic [3:0] F_SLT = 4'b0101;
    localparam logic [3:0] F_SUB = 4'b0110;
    localparam logic [3:0] F_SRA = 4'b0111;
    localparam logic [3:0] F_XOR = 4'b1001;
    localparam logic [3:0] F_BNE = 4'b1100;
    localparam logic [3:0] F_SRL = 4'b1111;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [3:0]      funct_q, funct_d;
    logic [4:0]      cnt_q, cnt_d;
    logic [XLEN-1:0] res_q, res_d;
    logic            br_q, br_d;

    logic            is_shift;
    logic [4:0]      shamt;
    logic [XLEN-1:0] diff;
    logic [XLEN-1:0] alu_res;
    logic            alu_br;
    logic [XLEN-1:0] shift_step;

    assign is_shift = (funct == F_SLL) || (funct == F_SRL) || (funct == F_SRA);
    assign shamt    = op_b[4:0];
    assign diff     = op_a - op_b;

    // Single-cycle functions; unlisted codes fall through to ADD.
    always_comb begin
        alu_res = op_a + op_b;
        alu_br  = 1'b0;
        case (funct)
            F_AND: alu_res = op_a & op_b;
            F_OR:  alu_res = op_a | op_b;
            F_XOR: alu_res = op_a ^ op_b;
            F_SUB: alu_res = diff;
            F_SLT: alu_res = {{(XLEN-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
            F_BEQ: begin
                alu_res = diff;
                alu_br  = (op_a == op_b);
            end
            F_BNE: begin
                alu_res = diff;
                alu_br  = (op_a != op_b);
            end
            default: alu_res = op_a + op_b;
        endcase
    end

    // One bit position per SHIFT cycle; direction/fill taken from the captured code.
    always_comb begin
        case (funct_q)
            F_SLL:   shift_step = {res_q[XLEN-2:0], 1'b0};
            F_SRA:   shift_step = {res_q[XLEN-1], res_q[XLEN-1:1]};
            default: shift_step = {1'b0, res_q[XLEN-1:1]};
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        if (flush) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        state_d = (is_shift && (shamt != 5'd0)) ? SHIFT : DONE;
                    end
                end
                SHIFT: begin
                    if (cnt_q == 5'd1) begin
                        state_d = DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state_d = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // Output logic
    always_comb begin
        in_ready  = (state_q == IDLE);
        out_valid = (state_q == DONE);
        result    = res_q;
        zero      = (res_q == '0);
        br_taken  = br_q;
    end

    // Datapath next-state: capture at acceptance, shift while in SHIFT, hold otherwise.
    always_comb begin
        funct_d = funct_q;
        cnt_d   = cnt_q;
        res_d   = res_q;
        br_d    = br_q;
        if (flush) begin
            cnt_d = 5'd0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        funct_d = funct;
                        cnt_d   = is_shift ? shamt : 5'd0;
                        res_d   = is_shift ? op_a : alu_res;
                        br_d    = is_shift ? 1'b0 : alu_br;
                    end
                end
                SHIFT: begin
                    res_d = shift_step;
                    cnt_d = cnt_q - 5'd1;
                end
                default: begin
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            funct_q <= 4'd0;
            cnt_q   <= 5'd0;
            res_q   <= '0;
            br_q    <= 1'b0;
        end else begin
            funct_q <= funct_d;
            cnt_q   <= cnt_d;
            res_q   <= res_d;
            br_q    <= br_d;
        end
    end

endmodule

// File: tb/tb_alu_exec.sv
// tb/tb_alu_exec.sv - directed self-checking bench for alu_exec
module tb_alu_exec;

    logic        clk;
    logic        rstn;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  funct;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;
    logic        zero;
    logic        br_taken;

    int n_tests = 0;
    int n_fail  = 0;

    alu_exec #(.XLEN(32)) dut (
        .clk       (clk),
        .rstn      (rstn),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .funct     (funct),
        .op_a      (op_a),
        .op_b      (op_b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .zero      (zero),
        .br_taken  (br_taken)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Issue one op from IDLE with out_ready=1, check latency, busy cycles, outputs, return to IDLE.
    task automatic do_op(input string tag, input logic [3:0] f, input logic [31:0] a,
                         input logic [31:0] b, input int exp_lat, input logic [31:0] exp_res,
                         input logic exp_br);
        int lat;
        int busy;
        @(negedge clk);
        out_ready = 1'b1;
        in_valid  = 1'b1;
        funct     = f;
        op_a      = a;
        op_b      = b;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        lat  = 1;
        busy = 0;
        while (!out_valid && lat < 64) begin
            if (!in_ready) busy++;
            @(posedge clk);
            #1;
            lat++;
        end
        if (!in_ready) busy++;
        chk({tag, "_lat"}, lat, exp_lat);
        chk({tag, "_busy"}, busy, exp_lat);
        chk({tag, "_res"}, result, exp_res);
        chk({tag, "_zero"}, {31'd0, zero}, {31'd0, exp_res == 32'd0});
        chk({tag, "_br"}, {31'd0, br_taken}, {31'd0, exp_br});
        @(posedge clk);
        #1;
        chk({tag, "_idle"}, {31'd0, in_ready, out_valid}, 32'd2);
    endtask

    task automatic no_valid_for(input string tag, input int cycles);
        int seen = 0;
        for (int i = 0; i < cycles; i++) begin
            @(posedge clk);
            #1;
            if (out_valid) seen++;
        end
        chk(tag, seen, 0);
    endtask

    initial begin
        rstn      = 1'b0;
        flush     = 1'b0;
        in_valid  = 1'b0;
        funct     = 4'd0;
        op_a      = 32'd0;
        op_b      = 32'd0;
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_outs", {27'd0, in_ready, out_valid, zero, br_taken, 1'b0}, 32'b10100);
        chk("rst_res", result, 32'd0);
        @(negedge clk);
        rstn = 1'b1;

        do_op("add_wrap", 4'b0010, 32'hFFFF_FFFF, 32'd1, 1, 32'd0, 1'b0);
        do_op("sra",      4'b0111, 32'h8000_0000, 32'd4, 5, 32'hF800_0000, 1'b0);
        do_op("srl",      4'b1111, 32'h8000_0000, 32'd4, 5, 32'h0800_0000, 1'b0);
        do_op("bne_eq",   4'b1100, 32'd5, 32'd5, 1, 32'd0, 1'b0);
        do_op("beq_eq",   4'b0100, 32'd5, 32'd5, 1, 32'd0, 1'b1);
        do_op("beq_ne",   4'b0100, 32'd9, 32'd5, 1, 32'd4, 1'b0);
        do_op("bne_ne",   4'b1100, 32'd3, 32'd5, 1, 32'hFFFF_FFFE, 1'b1);
        do_op("slt_neg",  4'b0101, 32'hFFFF_FFFF, 32'd1, 1, 32'd1, 1'b0);
        do_op("slt_pos",  4'b0101, 32'd1, 32'hFFFF_FFFF, 1, 32'd0, 1'b0);
        do_op("and",      4'b0000, 32'hF0F0_1234, 32'h0FF0_FF00, 1, 32'h00F0_1200, 1'b0);
        do_op("or",       4'b0001, 32'hF000_0001, 32'h0000_0F00, 1, 32'hF000_0F01, 1'b0);
        do_op("xor",      4'b1001, 32'hAAAA_5555, 32'hFFFF_0000, 1, 32'h5555_5555, 1'b0);
        do_op("sub_wrap", 4'b0110, 32'd0, 32'd1, 1, 32'hFFFF_FFFF, 1'b0);
        do_op("sll0",     4'b0011, 32'h1234_5678, 32'd0, 1, 32'h1234_5678, 1'b0);
        do_op("sll3",     4'b0011, 32'd1, 32'd3, 4, 32'd8, 1'b0);
        do_op("sll_lo5",  4'b0011, 32'd1, 32'h0000_0021, 2, 32'd2, 1'b0);
        do_op("sra_pos",  4'b0111, 32'h4000_0000, 32'd2, 3, 32'h1000_0000, 1'b0);
        do_op("sra31",    4'b0111, 32'h8000_0000, 32'd31, 32, 32'hFFFF_FFFF, 1'b0);

        // Result held while out_ready low; input changes ignored.
        @(negedge clk);
        out_ready = 1'b0;
        in_valid  = 1'b1;
        funct     = 4'b0010;
        op_a      = 32'd10;
        op_b      = 32'd20;
        @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("hold_v%0d", i), {31'd0, out_valid}, 32'd1);
            chk($sformatf("hold_r%0d", i), result, 32'd30);
            op_a  = 32'd100 + i;
            funct = 4'b0110;
            @(posedge clk);
            #1;
        end
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("hold_idle", {31'd0, in_ready, out_valid}, 32'd2);
        chk("hold_keep", result, 32'd30);

        // Flush mid-SHIFT.
        @(negedge clk);
        in_valid = 1'b1;
        funct    = 4'b0011;
        op_a     = 32'd1;
        op_b     = 32'd31;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (9) @(posedge clk);
        @(negedge clk);
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        chk("flush_idle", {31'd0, in_ready, out_valid}, 32'd2);
        no_valid_for("flush_noval", 40);

        // Flush in IDLE blocks a same-cycle accept.
        @(negedge clk);
        flush    = 1'b1;
        in_valid = 1'b1;
        funct    = 4'b0010;
        op_a     = 32'd1;
        op_b     = 32'd1;
        @(posedge clk);
        #1;
        flush    = 1'b0;
        in_valid = 1'b0;
        chk("flush_noacc", {31'd0, in_ready, out_valid}, 32'd2);
        do_op("post_flush_add", 4'b0010, 32'd2, 32'd3, 1, 32'd5, 1'b0);

        // Asynchronous reset mid-SHIFT.
        @(negedge clk);
        in_valid = 1'b1;
        funct    = 4'b1111;
        op_a     = 32'hFFFF_FFFF;
        op_b     = 32'd20;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        chk("pre_rst_busy", {31'd0, in_ready}, 32'd0);
        rstn = 1'b0;
        #1;
        chk("arst_outs", {28'd0, in_ready, out_valid, zero, br_taken}, 32'b1010);
        chk("arst_res", result, 32'd0);
        @(negedge clk);
        rstn = 1'b1;
        no_valid_for("arst_noval", 30);
        do_op("undef1010", 4'b1010, 32'd7, 32'd8, 1, 32'd15, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
